// File: rtl/booth.sv
// Sequential radix-2 Booth multiplier: LOAD -> N ITER edges -> DONE, product registered on DONE entry.
// Optional macro BOOTH_AUTO_RESTART_EN restarts the multiply when m or q changes while in DONE.
module booth #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   m,
    input  logic [N-1:0]   q,
    output logic [2*N-1:0] result
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {LOAD, ITER, DONE} state_t;

    state_t          state;
    logic [N:0]      a_reg;
    logic [N:0]      m_reg;
    logic [N-1:0]    q_reg;
    logic            q_1;
    logic [CW-1:0]   count;
    logic [N:0]      a_sum;
`ifdef BOOTH_AUTO_RESTART_EN
    logic [N-1:0]    q_lat;
`endif

    // Extra accumulator bit keeps A-M exact when M is the most negative operand.
    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_1})
            2'b10:   a_sum = a_reg - m_reg;
            2'b01:   a_sum = a_reg + m_reg;
            default: a_sum = a_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= LOAD;
            a_reg  <= '0;
            m_reg  <= '0;
            q_reg  <= '0;
            q_1    <= 1'b0;
            count  <= '0;
            result <= '0;
`ifdef BOOTH_AUTO_RESTART_EN
            q_lat  <= '0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    a_reg <= '0;
                    m_reg <= {m[N-1], m};
                    q_reg <= q;
                    q_1   <= 1'b0;
                    count <= CW'(N);
`ifdef BOOTH_AUTO_RESTART_EN
                    q_lat <= q;
`endif
                    state <= ITER;
                end
                ITER: begin
                    if (count != '0) begin
                        a_reg <= {a_sum[N], a_sum[N:1]};
                        q_reg <= {a_sum[0], q_reg[N-1:1]};
                        q_1   <= q_reg[0];
                        count <= count - 1'b1;
                    end else begin
                        result <= {a_reg[N-1:0], q_reg};
                        state  <= DONE;
                    end
                end
                DONE: begin
`ifdef BOOTH_AUTO_RESTART_EN
                    // Compare against the operands captured at LOAD, not the shifted Q.
                    if (m != m_reg[N-1:0] || q != q_lat)
                        state <= LOAD;
                    else
                        state <= DONE;
`else
                    state <= DONE;
`endif
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_booth.sv
// Self-checking bench for booth (N=4): scoreboard of expected products, directed corners plus random pairs.
module tb_booth;
    localparam int N = 4;
    localparam int W = 2 * N;

    logic         clk;
    logic         rst;
    logic [N-1:0] m;
    logic [N-1:0] q;
    logic [W-1:0] result;

    logic [W-1:0] exp_q[$];
    int total;
    int bad;

    booth #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .m      (m),
        .q      (q),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%02h expected=0x%02h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [N-1:0] mv, input logic [N-1:0] qv);
        logic signed [W-1:0] p;
        p = $signed(mv) * $signed(qv);
        return p;
    endfunction

    // Apply operands, push the expected product, pulse rst low for one cycle.
    task automatic start(input logic [N-1:0] mv, input logic [N-1:0] qv);
        @(negedge clk);
        m = mv;
        q = qv;
        exp_q.push_back(model(mv, qv));
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Result must still be 0 after edge N+1 and hold the product after edge N+2.
    task automatic finish_check(input string tag);
        logic [W-1:0] e;
        repeat (N + 1) @(posedge clk);
        #1 check({tag, "_early"}, result, '0);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, result, 'x);
        end else begin
            e = exp_q.pop_front();
            check(tag, result, e);
        end
    endtask

    initial begin
        logic [W-1:0] e;
        total = 0;
        bad = 0;
        rst = 1'b0;
        m = '0;
        q = '0;
        #12;
        check("reset", result, '0);

        start(4'd3, 4'd2);
        finish_check("m3_q2");
        repeat (10) @(posedge clk);
        #1 check("hold_100ns", result, 8'h06);

        start(4'hD, 4'd2);
        finish_check("mneg3_q2");
        start(4'hC, 4'hD);
        finish_check("mneg4_qneg3");
        start(4'd0, 4'd5);
        finish_check("m0_q5");
        start(4'h8, 4'h8);
        finish_check("mneg8_qneg8");
        start(4'h8, 4'd7);
        finish_check("mneg8_q7");

        // Operands change during ITER must be ignored.
        start(4'hD, 4'd7);
        repeat (2) @(posedge clk);
        #1;
        m = 4'd5;
        q = 4'd1;
        repeat (3) @(posedge clk);
        #1 check("iter_change_early", result, '0);
        @(posedge clk);
        #1 e = exp_q.pop_front();
        check("iter_change", result, e);

        // Reset at edge 3 aborts: result clears immediately, then a fresh product.
        start(4'd3, 4'd2);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("abort_clear", result, '0);
        @(negedge clk);
        rst = 1'b1;
        finish_check("abort_restart");

        for (int i = 0; i < 8; i++) begin
            start(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
            finish_check("random");
        end

        // Operand change in DONE: restart only when the macro is built in.
        start(4'd3, 4'd2);
        finish_check("pre_restart");
        @(negedge clk);
        q = 4'd3;
`ifdef BOOTH_AUTO_RESTART_EN
        exp_q.push_back(8'h09);
`else
        exp_q.push_back(8'h06);
`endif
        repeat (6) @(posedge clk);
        #1 check("restart_hold", result, 8'h06);
        @(posedge clk);
        #1 e = exp_q.pop_front();
        check("restart_result", result, e);
        repeat (4) @(posedge clk);
        #1 check("restart_stable", result, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/booth.md
BOOTH -- requirements
Module: booth

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset, which also serves as the start command.
REQ-004 The module SHALL have port m, input, N bits: multiplicand, two's complement.
REQ-005 The module SHALL have port q, input, N bits: multiplier, two's complement.
REQ-006 The module SHALL have port result, output, 2N bits: registered signed product m*q.
REQ-007 The design SHALL use one clock, and rst SHALL be asynchronous and active-low, with no other clocks or resets.

Function
REQ-008 The design SHALL implement radix-2 Booth multiplication as a sequential FSM with states LOAD, ITER, DONE.
REQ-009 In LOAD, on the first rising clk edge after rst deasserts, the design SHALL set A<=0 (N+1 bits, sign-extended accumulator), Q<=q, Q_1<=0, M<=m sign-extended to N+1 bits, count<=N, and go to ITER.
REQ-010 In ITER, each edge SHALL act on {Q[0],Q_1}: 10 gives A<=A-M, 01 gives A<=A+M, 00/11 leave A unchanged.
REQ-011 In the same ITER edge, the design SHALL arithmetic-shift {A,Q,Q_1} right by one, preserving the A MSB, and decrement count.
REQ-012 When count reaches 0, the FSM SHALL go to DONE after exactly N ITER edges.
REQ-013 On the DONE entry edge, result SHALL be loaded with the low 2N bits of {A,Q}.
REQ-014 result SHALL update only on the DONE entry edge and SHALL hold between updates; it SHALL NOT show partial products.
REQ-015 Latency SHALL be: result valid after rising edge N+2 counted from rst deassertion (edge 6 for N=4).
REQ-016 The product SHALL be exact for all operand pairs, including m=q=-2^(N-1), where -8*-8 gives 0x40 for N=4.
REQ-017 The internal (N+1)-bit accumulator SHALL prevent overflow of A-M when M=-2^(N-1).
REQ-018 m and q SHALL be sampled only in LOAD; changes during ITER SHALL be ignored.
REQ-019 The FSM SHALL stay in DONE, holding result, until reset or a restart per REQ-024.

Reset
REQ-020 While rst=0, result SHALL be 0, A/Q/Q_1/M/count SHALL be 0, and the FSM SHALL be in LOAD, all asynchronously.
REQ-021 Reset asserted mid-operation SHALL abort the computation immediately, clear result to 0, and restart from LOAD on deassertion.
REQ-022 After reset and before the first DONE, result SHALL read 0.

Configuration
REQ-023 Macro BOOTH_AUTO_RESTART_EN SHALL control automatic restart.
REQ-024 With BOOTH_AUTO_RESTART_EN defined, in DONE a difference between m or q and the values latched at LOAD SHALL move the FSM to LOAD on the next edge, and result SHALL hold its old value until the new DONE entry.
REQ-025 Without BOOTH_AUTO_RESTART_EN, operand changes in DONE SHALL be ignored, and only a rst pulse SHALL start a new multiplication.

Verification
REQ-026 The bench SHALL check m=3, q=2, rst pulse low for 1 cycle: result=0x06 at edge 6 after release and held through 100 ns.
REQ-027 The bench SHALL check m=-3, q=2: result=0xFA (-6).
REQ-028 The bench SHALL check m=-4, q=-3: result=0x0C (12), and m=0, q=5: result=0x00.
REQ-029 The bench SHALL check corner cases: m=-8, q=-8 gives 0x40, and m=-8, q=7 gives 0xC8 (-56).
REQ-030 The bench SHALL check that rst asserted at edge 3 of a computation gives result=0 immediately and the correct product 6 edges after release.
REQ-031 With BOOTH_AUTO_RESTART_EN, the bench SHALL check that changing q from 2 to 3 in DONE (m=3) holds 0x06 until the new DONE and then gives 0x09; without the macro, result SHALL stay 0x06.
